// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the simple-bus arbiter.
package arvi_bus_pkg;

    localparam int BYTE_EN_W = 4;
    localparam int BUS_XLEN  = 32;

    typedef enum logic {
        IDLE,
        BUSY
    } arb_state_e;

    // One registered bus request as presented on the shared bus.
    typedef struct packed {
        logic                 wr_en;
        logic [BUS_XLEN-1:0]  addr;
        logic [BUS_XLEN-1:0]  wr_data;
        logic [BYTE_EN_W-1:0] byte_en;
    } bus_req_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Per-master request/response lanes plus the shared slave bus.
interface bus_arbiter_if #(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32
);
    import arvi_bus_pkg::*;

    logic [N_MASTERS-1:0]           i_m_bus_en;
    logic [N_MASTERS-1:0]           i_m_wr_en;
    logic [N_MASTERS*XLEN-1:0]      i_m_addr;
    logic [N_MASTERS*XLEN-1:0]      i_m_wr_data;
    logic [N_MASTERS*BYTE_EN_W-1:0] i_m_byte_en;
    logic [N_MASTERS-1:0]           o_m_ack;
    logic [N_MASTERS-1:0]           o_m_err;
    logic [XLEN-1:0]                o_m_rd_data;
    logic                           o_bus_en;
    logic                           o_wr_en;
    logic [XLEN-1:0]                o_addr;
    logic [XLEN-1:0]                o_wr_data;
    logic [BYTE_EN_W-1:0]           o_byte_en;
    logic                           i_ack;
    logic [XLEN-1:0]                i_rd_data;
    logic [$clog2(N_MASTERS)-1:0]   o_grant;

    // Arbiter view: it masters the shared bus on behalf of the requesters.
    modport master (
        input  i_m_bus_en, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        output o_m_ack, o_m_err, o_m_rd_data,
        output o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, o_grant,
        input  i_ack, i_rd_data
    );

    // Environment view: requesting masters and the bus slave.
    modport slave (
        output i_m_bus_en, i_m_wr_en, i_m_addr, i_m_wr_data, i_m_byte_en,
        input  o_m_ack, o_m_err, o_m_rd_data,
        input  o_bus_en, o_wr_en, o_addr, o_wr_data, o_byte_en, o_grant,
        output i_ack, i_rd_data
    );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin selector: first set request bit strictly after ptr, with wrap.
module rr_pick #(
    parameter int N_MASTERS = 2
) (
    input  logic [N_MASTERS-1:0]         req,
    input  logic [$clog2(N_MASTERS)-1:0] ptr,
    output logic                         valid,
    output logic [$clog2(N_MASTERS)-1:0] idx
);
    localparam int unsigned N_U   = N_MASTERS;
    localparam int          IDX_W = $clog2(N_MASTERS);

    // Scan ptr+1 .. ptr+N modulo N; the first hit wins.
    always_comb begin
        int unsigned k;
        valid = 1'b0;
        idx   = '0;
        k     = 0;
        for (int unsigned i = 1; i <= N_U; i++) begin
            k = (32'(ptr) + i) % N_U;
            if (!valid && req[k]) begin
                valid = 1'b1;
                idx   = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one simple memory bus among N masters,
// with a watchdog that aborts transactions the slave never acknowledges.
module bus_arbiter
    import arvi_bus_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int XLEN      = 32,
    parameter int TIMEOUT   = 256
) (
    input logic            i_clk,
    input logic            i_rst,
    bus_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(N_MASTERS);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    // The registered request uses the package struct, whose width is fixed.
    if (XLEN != BUS_XLEN) begin : g_xlen_check
        $error("bus_arbiter: XLEN must equal arvi_bus_pkg::BUS_XLEN");
    end

    arb_state_e         state_q, state_d;
    bus_req_t           req_q, req_d;
    logic               bus_en_q, bus_en_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               timeout;

    rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
        .req   (bus.i_m_bus_en),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign timeout = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State register, bus output registers, round-robin pointer and watchdog.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            req_q    <= '0;
            bus_en_q <= 1'b0;
            grant_q  <= '0;
            ptr_q    <= IDX_W'(N_MASTERS - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            bus_en_q <= bus_en_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state: grant in IDLE, hold the bus frozen in BUSY until ack or timeout.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        bus_en_d = bus_en_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                bus_en_d = 1'b0;
                cnt_d    = '0;
                if (pick_valid) begin
                    req_d.wr_en   = bus.i_m_wr_en[pick_idx];
                    req_d.addr    = bus.i_m_addr[int'(pick_idx)*XLEN +: XLEN];
                    req_d.wr_data = bus.i_m_wr_data[int'(pick_idx)*XLEN +: XLEN];
                    req_d.byte_en = bus.i_m_byte_en[int'(pick_idx)*BYTE_EN_W +: BYTE_EN_W];
                    bus_en_d      = 1'b1;
                    grant_d       = pick_idx;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.i_ack || timeout) begin
                    bus_en_d    = 1'b0;
                    req_d.wr_en = 1'b0;
                    ptr_d       = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: ack/err decoded from state, bus driven from registers.
    always_comb begin
        bus.o_m_ack     = '0;
        bus.o_m_err     = '0;
        bus.o_m_rd_data = bus.i_rd_data;
        bus.o_bus_en    = bus_en_q;
        bus.o_wr_en     = req_q.wr_en;
        bus.o_addr      = req_q.addr;
        bus.o_wr_data   = req_q.wr_data;
        bus.o_byte_en   = req_q.byte_en;
        bus.o_grant     = grant_q;
        if (state_q == BUSY) begin
            // Ack takes precedence over a coincident watchdog expiry.
            if (bus.i_ack) begin
                bus.o_m_ack[grant_q] = 1'b1;
            end else if (timeout) begin
                bus.o_m_err[grant_q] = 1'b1;
            end
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter that shares the single simple memory bus between N bus masters, for example the bus adapters of several cores or a DMA engine.
- Each master drives the same request format the bus adapter emits: bus_en held until ack, plus wr_en, addr, wr_data and byte_en.
- The arbiter grants one master at a time and registers that master's request onto the shared bus.
- It routes the slave's ack and read data back to the granted master.
- A watchdog aborts transactions that never receive an ack.

Parameters:
N_MASTERS, 2, number of requesting masters (2..8).
XLEN, 32, address and data width.
TIMEOUT, 256, cycles in BUSY without i_ack before abort; 0 disables the watchdog.

Ports:
i_clk  in  1  clock, rising edge.
i_rst  in  1  reset, asynchronous, active-low.
i_m_bus_en  in  N_MASTERS  per-master request, held until its ack.
i_m_wr_en  in  N_MASTERS  per-master write enable.
i_m_addr  in  N_MASTERS*XLEN  per-master address, packed, master k at [k*XLEN +: XLEN].
i_m_wr_data  in  N_MASTERS*XLEN  per-master write data, packed the same way.
i_m_byte_en  in  N_MASTERS*4  per-master byte enables, packed.
o_m_ack  out  N_MASTERS  one-hot ack to the granted master.
o_m_err  out  N_MASTERS  one-hot timeout error to the granted master.
o_m_rd_data  out  XLEN  read data, broadcast to all masters.
o_bus_en  out  1  shared bus request.
o_wr_en  out  1  shared bus write enable.
o_addr  out  XLEN  shared bus address.
o_wr_data  out  XLEN  shared bus write data.
o_byte_en  out  4  shared bus byte enables.
i_ack  in  1  slave acknowledge, single-cycle pulse.
i_rd_data  in  XLEN  slave read data, valid with i_ack.
o_grant  out  $clog2(N_MASTERS)  index of the current or last grant (debug).

Behaviour:
- Reset (async, i_rst=0): state IDLE; all bus outputs 0; o_grant 0; ptr=N_MASTERS-1, so master 0 has first priority; watchdog count 0. o_m_ack and o_m_err are 0 because they are decoded from state.
- States:
  - IDLE: if any i_m_bus_en bit is set, pick the first requester searching from (ptr+1) mod N upward with wrap. Register its wr_en, addr, wr_data and byte_en onto the bus outputs. Set o_bus_en=1, o_grant=index, count=0, go to BUSY. No requester: stay in IDLE, outputs hold, o_bus_en=0.
  - BUSY: bus outputs frozen; count increments each cycle.
    - On i_ack: o_m_ack[o_grant]=1 combinationally in the same cycle; o_m_rd_data=i_rd_data. Next edge: o_bus_en=0, o_wr_en=0, ptr=o_grant, go to IDLE.
    - On timeout (TIMEOUT!=0, count==TIMEOUT-1, no i_ack): o_m_err[o_grant]=1 for that cycle, no ack. Next edge: o_bus_en=0, ptr=o_grant, go to IDLE.
- Latency:
  - Request sampled at edge t gives o_bus_en=1 after edge t.
  - Ack in cycle c gives o_bus_en=0 after edge c.
  - At least one idle bus cycle between transactions; a held request is re-granted no earlier than 2 cycles after its ack.
- o_m_rd_data equals i_rd_data at all times; it is meaningful only with o_m_ack.
- i_ack while in IDLE is ignored; no o_m_ack is asserted.
- i_ack and timeout in the same cycle: ack wins and o_m_err stays 0.
- Granted master drops i_m_bus_en mid-transaction: the transaction still runs to ack or timeout, and the ack is still pulsed to that master.
- Changes to the granted master's inputs during BUSY are ignored.
- Fairness: with all masters requesting continuously, grants rotate 0,1,...,N-1,0,...
- The watchdog counter is wide enough for TIMEOUT; there is no wrap in BUSY because timeout exits first.

Decomposition:
- Package arvi_bus_pkg holds:
  - the state enum {IDLE, BUSY};
  - the bus request struct {wr_en, addr, wr_data, byte_en};
  - constant BYTE_EN_W=4.
- Sub-module rr_pick: purely combinational, inputs req[N] and ptr, outputs valid and idx (first set bit after ptr, with wrap).
- Top level holds the FSM, output registers, pointer and watchdog.

Test Plan:
- Single read: master 1 requests addr 0x0000_1004, wr_en=0; slave acks after 3 cycles with rd_data 0xDEAD_BEEF. Required: o_bus_en high for 3 cycles, o_addr=0x1004, o_m_ack=2'b10 for one cycle, o_m_rd_data=0xDEAD_BEEF.
- Simultaneous requests: masters 0 and 1 both request from reset, each acked after 1 cycle. Required: master 0 granted first, then master 1; o_grant sequence 0,1, with one idle bus cycle between.
- Fairness: N=4, all masters held requesting, ack every transaction after 1 cycle. Required: o_grant sequence 0,1,2,3,0,1 and no master granted twice in a row.
- Write pass-through: master 0 writes addr 0x20, wr_data 0x1234_5678, byte_en 4'b0011. Required: bus outputs match exactly and stay stable until ack, even if master 0 changes its addr to 0x40 mid-transaction.
- Timeout: TIMEOUT=8, master 1 requests and the slave never acks. Required: o_m_err=2'b10 in the 8th BUSY cycle, o_bus_en=0 on the next cycle, and a pending master 0 is granted next.
- Async reset mid-transaction: assert i_rst=0 while BUSY. Required: o_bus_en=0 immediately without waiting for a clock edge, and after release master 0 has priority.
